// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the serial 9-tap symmetric FIR.
// No logic; parameter defaults only.
// No handshake of its own.
package fir_pkg;

    localparam int DW_DEF = 8;
    localparam int OW_DEF = 18;

    // Symmetric half of the coefficient set; B5..B8 mirror B3..B0.
    localparam int B0_DEF = 7;
    localparam int B1_DEF = 17;
    localparam int B2_DEF = 32;
    localparam int B3_DEF = 46;
    localparam int B4_DEF = 52;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/fir_mac.sv
// Pre-adder, single multiplier and accumulator for one symmetric tap pair per step.
// Accumulator updates one edge after enable; o_sum is the combinational running total.
// No backpressure; the caller sequences steps through i_en and i_step.
module fir_mac #(
    parameter int DW = 8,
    parameter int OW = 18,
    parameter int B0 = 7,
    parameter int B1 = 17,
    parameter int B2 = 32,
    parameter int B3 = 46,
    parameter int B4 = 52
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [3:0]    i_step,
    input  logic [DW-1:0] i_xa,
    input  logic [DW-1:0] i_xb,
    output logic [OW-1:0] o_sum
);

    localparam int CW = 6;
    localparam int PW = DW + 1 + CW;

    logic [OW-1:0] r_acc;
    logic [DW:0]   w_pre;
    logic [CW-1:0] w_coef;
    logic [PW-1:0] w_prod;
    logic [OW-1:0] w_sum;

    assign w_pre = {1'b0, i_xa} + {1'b0, i_xb};

    always_comb begin
        w_coef = '0;
        case (i_step)
            4'd0:    w_coef = CW'(B0);
            4'd1:    w_coef = CW'(B1);
            4'd2:    w_coef = CW'(B2);
            4'd3:    w_coef = CW'(B3);
            4'd4:    w_coef = CW'(B4);
            default: w_coef = '0;
        endcase
    end

    assign w_prod = {{CW{1'b0}}, w_pre} * {{(DW + 1){1'b0}}, w_coef};
    assign w_sum  = r_acc + {{(OW - PW){1'b0}}, w_prod};
    assign o_sum  = w_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/fir_serial.sv
// Time-multiplexed 9-tap symmetric FIR: one sample in, one filtered result out.
// Result valid 5 edges after acceptance; next sample accepted one edge after the result is taken.
// Holds dout/dout_valid while dout_ready=0; din_ready stays low until the result is consumed.
module fir_serial
    import fir_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF,
    parameter int B0 = B0_DEF,
    parameter int B1 = B1_DEF,
    parameter int B2 = B2_DEF,
    parameter int B3 = B3_DEF,
    parameter int B4 = B4_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_din,
    input  logic          i_din_valid,
    output logic          o_din_ready,
    output logic [OW-1:0] o_dout,
    output logic          o_dout_valid,
    input  logic          i_dout_ready
);

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_x [0:8];
    logic [3:0]    r_step;
    logic          r_din_ready;
    logic [OW-1:0] r_dout;
    logic          r_dout_valid;

    logic          w_accept;
    logic          w_mac_en;
    logic          w_last;
    logic [DW-1:0] w_xa;
    logic [DW-1:0] w_xb;
    logic [OW-1:0] w_sum;

    assign w_accept = i_din_valid & r_din_ready;

    always_comb begin
        w_next   = r_state;
        w_mac_en = 1'b0;
        w_last   = 1'b0;
        w_xa     = '0;
        w_xb     = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = MAC;
            end
            MAC: begin
                w_mac_en = 1'b1;
                w_xa     = r_x[r_step];
                // The centre tap has no mirror partner.
                if (r_step == 4'd4) begin
                    w_last = 1'b1;
                    w_next = OUT;
                end else begin
                    w_xb = r_x[4'd8 - r_step];
                end
            end
            OUT: begin
                if (i_dout_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_step       <= '0;
            r_din_ready  <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            for (int k = 0; k < 9; k++) r_x[k] <= '0;
        end else begin
            r_state     <= w_next;
            r_din_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_step <= '0;
                r_x[0] <= i_din;
                for (int k = 8; k > 0; k--) r_x[k] <= r_x[k-1];
            end else if (w_mac_en) begin
                r_step <= r_step + 4'd1;
            end
            if (w_last) begin
                r_dout       <= w_sum;
                r_dout_valid <= 1'b1;
            end else if (r_state == OUT && i_dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    fir_mac #(
        .DW (DW),
        .OW (OW),
        .B0 (B0),
        .B1 (B1),
        .B2 (B2),
        .B3 (B3),
        .B4 (B4)
    ) u_mac (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_accept),
        .i_en    (w_mac_en),
        .i_step  (r_step),
        .i_xa    (w_xa),
        .i_xb    (w_xb),
        .o_sum   (w_sum)
    );

    assign o_din_ready  = r_din_ready;
    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;

endmodule

// File: tb/tb_fir_serial.sv
// Directed plus randomized bench for fir_serial against a sum-of-products reference model.
module tb_fir_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [17:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    int checks = 0;
    int errors = 0;
    int mx [9];
    int cf [9] = '{7, 17, 32, 46, 52, 46, 32, 17, 7};
    int imp_tab [10] = '{7, 17, 32, 46, 52, 46, 32, 17, 7, 0};
    int stp_tab [10] = '{1785, 6120, 14280, 26010, 39270, 51000, 59160, 63495, 65280, 65280};

    always #5 clk = ~clk;

    fir_serial dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .o_din_ready  (din_ready),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .i_dout_ready (dout_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_y();
        int s = 0;
        for (int k = 0; k < 9; k++) s += cf[k] * mx[k];
        return s;
    endfunction

    task automatic model_push(input int s);
        for (int k = 8; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = s;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 9; k++) mx[k] = 0;
    endtask

    // Offers one sample, follows it through MAC and OUT, holding the result for 'hold' cycles.
    task automatic feed(input logic [7:0] s, input int hold);
        int n;
        int exp;
        n = 0;
        while (!din_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'b0, din_ready}, 32'd1);
        din        = s;
        din_valid  = 1'b1;
        dout_ready = 1'($urandom);
        @(negedge clk);
        model_push(int'(s));
        exp = model_y();
        din_valid = 1'($urandom);
        din       = 8'($urandom);
        chk("ready_low_after_accept", {31'b0, din_ready}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            dout_ready = 1'($urandom);
            din        = 8'($urandom);
            @(negedge clk);
            chk("no_early_valid", {31'b0, dout_valid}, 32'd0);
        end
        dout_ready = 1'($urandom);
        @(negedge clk);
        chk("dout_valid_at_e5", {31'b0, dout_valid}, 32'd1);
        chk("dout_value", 32'(dout), 32'(exp));
        dout_ready = 1'b0;
        din_valid  = 1'b1;
        for (int i = 0; i < hold; i++) begin
            din = 8'($urandom);
            @(negedge clk);
            chk("hold_dout", 32'(dout), 32'(exp));
            chk("hold_valid", {31'b0, dout_valid}, 32'd1);
            chk("hold_ready", {31'b0, din_ready}, 32'd0);
        end
        dout_ready = 1'b1;
        din_valid  = 1'b0;
        @(negedge clk);
        chk("valid_cleared", {31'b0, dout_valid}, 32'd0);
        chk("dout_kept", 32'(dout), 32'(exp));
        chk("ready_back", {31'b0, din_ready}, 32'd1);
        dout_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", {31'b0, dout_valid}, 32'd0);
        chk("rst_ready", {31'b0, din_ready}, 32'd0);
        rst_n = 1'b1;
        chk("ready_before_first_edge", {31'b0, din_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_first_edge", {31'b0, din_ready}, 32'd1);

        // Impulse response
        for (int i = 0; i < 10; i++) begin
            feed((i == 0) ? 8'd1 : 8'd0, 0);
            chk("impulse", 32'(dout), 32'(imp_tab[i]));
        end

        // Step response with long backpressure on one result
        for (int i = 0; i < 10; i++) begin
            feed(8'd255, (i == 4) ? 10 : 0);
            chk("step", 32'(dout), 32'(stp_tab[i]));
        end

        // Idle hold: nothing offered, no result appears, line must be unchanged afterwards
        din_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            din        = 8'($urandom);
            dout_ready = 1'($urandom);
            @(negedge clk);
            chk("idle_no_valid", {31'b0, dout_valid}, 32'd0);
        end
        dout_ready = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            feed(8'($urandom), $urandom_range(0, 3));
        end

        // Reset two edges after accepting 200
        din       = 8'd200;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midmac_rst_dout", 32'(dout), 32'd0);
        chk("midmac_rst_valid", {31'b0, dout_valid}, 32'd0);
        chk("midmac_rst_ready", {31'b0, din_ready}, 32'd0);
        model_clear();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_held_valid", {31'b0, dout_valid}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", {31'b0, dout_valid}, 32'd0);
        end
        feed(8'd1, 0);
        chk("post_rst_first", 32'(dout), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
